// File: rtl/vx_ti_slab_intersect.sv
// Four-stage ray/AABB slab test in signed fixed point with a valid/ready handshake,
// tag passthrough and saturating request/hit counters.
module vx_ti_slab_intersect #(
    parameter string       INSTANCE_ID = "",
    parameter int unsigned DATAW       = 32,
    parameter int unsigned FRACW       = 16,
    parameter int unsigned TAGW        = 8,
    parameter int unsigned PERFW       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic [TAGW-1:0]    tag_in,
    input  logic [3*DATAW-1:0] ray_orig,
    input  logic [3*DATAW-1:0] ray_inv_dir,
    input  logic [3*DATAW-1:0] box_min,
    input  logic [3*DATAW-1:0] box_max,
    input  logic [DATAW-1:0]   t_min,
    input  logic [DATAW-1:0]   t_max,
    output logic               valid_out,
    input  logic               ready_out,
    output logic [TAGW-1:0]    tag_out,
    output logic               hit_out,
    output logic [DATAW-1:0]   t_near_out,
    output logic [DATAW-1:0]   t_far_out,
    output logic [PERFW-1:0]   perf_reqs,
    output logic [PERFW-1:0]   perf_hits
);
    localparam int unsigned PW = 2 * DATAW + 1;
    localparam logic signed [DATAW-1:0] TMax = {1'b0, {(DATAW-1){1'b1}}};
    localparam logic signed [DATAW-1:0] TMin = {1'b1, {(DATAW-1){1'b0}}};

    logic stall, adv, acc;
    assign stall    = valid_out && !ready_out;
    assign adv      = !stall;
    assign ready_in = !stall;
    assign acc      = valid_in && ready_in;

    // Stage 1: slab offsets, parallel-axis and degenerate-box detection
    logic signed [DATAW-1:0] orig_w [3];
    logic signed [DATAW-1:0] inv_w  [3];
    logic signed [DATAW-1:0] min_w  [3];
    logic signed [DATAW-1:0] max_w  [3];
    logic signed [DATAW:0]   d0_w   [3];
    logic signed [DATAW:0]   d1_w   [3];
    logic                    par_w  [3];
    logic                    ins_w  [3];
    logic                    badbox_w;

    for (genvar a = 0; a < 3; a++) begin : g_axis
        assign orig_w[a] = ray_orig[a*DATAW +: DATAW];
        assign inv_w[a]  = ray_inv_dir[a*DATAW +: DATAW];
        assign min_w[a]  = box_min[a*DATAW +: DATAW];
        assign max_w[a]  = box_max[a*DATAW +: DATAW];
        assign d0_w[a]   = (DATAW+1)'(min_w[a]) - (DATAW+1)'(orig_w[a]);
        assign d1_w[a]   = (DATAW+1)'(max_w[a]) - (DATAW+1)'(orig_w[a]);
        assign par_w[a]  = (inv_w[a] == '0);
        assign ins_w[a]  = (min_w[a] <= orig_w[a]) && (orig_w[a] <= max_w[a]);
    end
    assign badbox_w = (min_w[0] > max_w[0]) || (min_w[1] > max_w[1]) || (min_w[2] > max_w[2]);

    logic                    s1_valid_q, s1_badbox_q;
    logic [TAGW-1:0]         s1_tag_q;
    logic signed [DATAW:0]   s1_d0_q  [3];
    logic signed [DATAW:0]   s1_d1_q  [3];
    logic signed [DATAW-1:0] s1_inv_q [3];
    logic                    s1_par_q [3];
    logic                    s1_ins_q [3];
    logic signed [DATAW-1:0] s1_tmin_q, s1_tmax_q;

    always_ff @(posedge clk) begin
        if (reset) s1_valid_q <= 1'b0;
        else if (adv) s1_valid_q <= acc;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_tag_q    <= tag_in;
            s1_badbox_q <= badbox_w;
            s1_tmin_q   <= t_min;
            s1_tmax_q   <= t_max;
            for (int a = 0; a < 3; a++) begin
                s1_d0_q[a]  <= d0_w[a];
                s1_d1_q[a]  <= d1_w[a];
                s1_inv_q[a] <= inv_w[a];
                s1_par_q[a] <= par_w[a];
                s1_ins_q[a] <= ins_w[a];
            end
        end
    end

    // Stage 2: full-width product, arithmetic rescale, saturate into DATAW
    function automatic logic signed [DATAW-1:0] scale(input logic signed [DATAW:0]   d,
                                                      input logic signed [DATAW-1:0] inv);
        logic signed [PW-1:0] p;
        p = (PW'(d) * PW'(inv)) >>> FRACW;
        if (p > PW'(TMax))      scale = TMax;
        else if (p < PW'(TMin)) scale = TMin;
        else                    scale = p[DATAW-1:0];
    endfunction

    logic signed [DATAW-1:0] t0_d [3];
    logic signed [DATAW-1:0] t1_d [3];
    logic                    pmiss_d;

    always_comb begin
        pmiss_d = 1'b0;
        for (int a = 0; a < 3; a++) begin
            t0_d[a] = scale(s1_d0_q[a], s1_inv_q[a]);
            t1_d[a] = scale(s1_d1_q[a], s1_inv_q[a]);
            if (s1_par_q[a]) begin
                t0_d[a] = TMin;
                t1_d[a] = TMax;
                if (!s1_ins_q[a]) pmiss_d = 1'b1;
            end
        end
    end

    logic                    s2_valid_q, s2_badbox_q, s2_pmiss_q;
    logic [TAGW-1:0]         s2_tag_q;
    logic signed [DATAW-1:0] s2_t0_q [3];
    logic signed [DATAW-1:0] s2_t1_q [3];
    logic signed [DATAW-1:0] s2_tmin_q, s2_tmax_q;

    always_ff @(posedge clk) begin
        if (reset) s2_valid_q <= 1'b0;
        else if (adv) s2_valid_q <= s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s2_tag_q    <= s1_tag_q;
            s2_badbox_q <= s1_badbox_q;
            s2_pmiss_q  <= pmiss_d;
            s2_tmin_q   <= s1_tmin_q;
            s2_tmax_q   <= s1_tmax_q;
            for (int a = 0; a < 3; a++) begin
                s2_t0_q[a] <= t0_d[a];
                s2_t1_q[a] <= t1_d[a];
            end
        end
    end

    // Stage 3: interval intersection across axes and the ray's own interval
    logic signed [DATAW-1:0] tn_d, tf_d;
    logic                    miss_d;

    always_comb begin
        logic signed [DATAW-1:0] lo, hi;
        tn_d   = s2_tmin_q;
        tf_d   = s2_tmax_q;
        miss_d = s2_pmiss_q || s2_badbox_q || (s2_tmin_q > s2_tmax_q);
        for (int a = 0; a < 3; a++) begin
            lo = (s2_t0_q[a] < s2_t1_q[a]) ? s2_t0_q[a] : s2_t1_q[a];
            hi = (s2_t0_q[a] < s2_t1_q[a]) ? s2_t1_q[a] : s2_t0_q[a];
            if (lo > tn_d) tn_d = lo;
            if (hi < tf_d) tf_d = hi;
        end
    end

    logic                    s3_valid_q, s3_miss_q;
    logic [TAGW-1:0]         s3_tag_q;
    logic signed [DATAW-1:0] s3_tn_q, s3_tf_q;

    always_ff @(posedge clk) begin
        if (reset) s3_valid_q <= 1'b0;
        else if (adv) s3_valid_q <= s2_valid_q;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s3_tag_q  <= s2_tag_q;
            s3_miss_q <= miss_d;
            s3_tn_q   <= tn_d;
            s3_tf_q   <= tf_d;
        end
    end

    // Stage 4: output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            tag_out    <= '0;
            hit_out    <= 1'b0;
            t_near_out <= '0;
            t_far_out  <= '0;
        end else if (adv) begin
            valid_out  <= s3_valid_q;
            tag_out    <= s3_tag_q;
            hit_out    <= (s3_tn_q <= s3_tf_q) && !s3_miss_q;
            t_near_out <= s3_tn_q;
            t_far_out  <= s3_tf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reqs <= '0;
            perf_hits <= '0;
        end else begin
            if (acc && (perf_reqs != '1)) perf_reqs <= perf_reqs + PERFW'(1);
            if (valid_out && ready_out && hit_out && (perf_hits != '1))
                perf_hits <= perf_hits + PERFW'(1);
        end
    end
endmodule

// File: tb/tb_vx_ti_slab_intersect.sv
// Randomised and directed bench for the slab-intersect pipeline against an
// arithmetic reference model with an in-order scoreboard.
module tb_vx_ti_slab_intersect;
    localparam int ONE = 65536;

    logic        clk = 1'b0;
    logic        reset, valid_in, ready_in, valid_out, ready_out, hit_out;
    logic [7:0]  tag_in, tag_out;
    logic [95:0] ray_orig, ray_inv_dir, box_min, box_max;
    logic [31:0] t_min, t_max, t_near_out, t_far_out, perf_reqs, perf_hits;
    logic        ready_in4, valid_out4, hit_out4;
    logic [7:0]  tag_out4;
    logic [31:0] t_near4, t_far4;
    logic [3:0]  perf_reqs4, perf_hits4;

    always #5 clk = ~clk;

    vx_ti_slab_intersect #(.INSTANCE_ID("tb32")) u_dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .tag_in(tag_in),
        .ray_orig(ray_orig), .ray_inv_dir(ray_inv_dir), .box_min(box_min), .box_max(box_max),
        .t_min(t_min), .t_max(t_max), .valid_out(valid_out), .ready_out(ready_out),
        .tag_out(tag_out), .hit_out(hit_out), .t_near_out(t_near_out), .t_far_out(t_far_out),
        .perf_reqs(perf_reqs), .perf_hits(perf_hits)
    );

    vx_ti_slab_intersect #(.INSTANCE_ID("tb4"), .PERFW(4)) u_dut4 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in4), .tag_in(tag_in),
        .ray_orig(ray_orig), .ray_inv_dir(ray_inv_dir), .box_min(box_min), .box_max(box_max),
        .t_min(t_min), .t_max(t_max), .valid_out(valid_out4), .ready_out(ready_out),
        .tag_out(tag_out4), .hit_out(hit_out4), .t_near_out(t_near4), .t_far_out(t_far4),
        .perf_reqs(perf_reqs4), .perf_hits(perf_hits4)
    );

    typedef struct {
        logic [7:0] tag;
        int orig[3]; int inv[3]; int bmin[3]; int bmax[3];
        int tmin; int tmax;
    } req_t;

    typedef struct {
        logic [7:0] tag; logic hit; int tn; int tf; bit cmp_t; int cyc; int stalls;
    } exp_t;

    req_t cur;
    exp_t q[$];
    int   n_checks = 0, n_errors = 0;
    int   pr = 0, ph = 0, outs = 0, cyc = 0, stalls = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Slab test from first principles: a parallel axis either admits everything or nothing.
    function automatic exp_t model(input req_t r);
        exp_t   e;
        longint t0, t1, lo, hi, tn, tf;
        bit     bad = 0, miss = 0;
        tn = r.tmin;
        tf = r.tmax;
        for (int a = 0; a < 3; a++) begin
            if (r.bmin[a] > r.bmax[a]) bad = 1;
            if (r.inv[a] == 0) begin
                if (r.orig[a] < r.bmin[a] || r.orig[a] > r.bmax[a]) miss = 1;
            end else begin
                t0 = sat(((longint'(r.bmin[a]) - longint'(r.orig[a])) * longint'(r.inv[a])) >>> 16);
                t1 = sat(((longint'(r.bmax[a]) - longint'(r.orig[a])) * longint'(r.inv[a])) >>> 16);
                lo = (t0 < t1) ? t0 : t1;
                hi = (t0 < t1) ? t1 : t0;
                if (lo > tn) tn = lo;
                if (hi < tf) tf = hi;
            end
        end
        e.tag   = r.tag;
        e.hit   = (tn <= tf) && !bad && !miss && (r.tmin <= r.tmax);
        e.tn    = int'(tn);
        e.tf    = int'(tf);
        e.cmp_t = !miss;
        e.cyc   = 0;
        e.stalls = 0;
        return e;
    endfunction

    function automatic int rc();
        return int'($urandom_range(0, 16 * ONE)) - 8 * ONE;
    endfunction

    function automatic req_t rand_req(input logic [7:0] tag);
        req_t r;
        bit   wild = ($urandom_range(0, 9) == 0);
        r.tag = tag;
        for (int a = 0; a < 3; a++) begin
            r.orig[a] = wild ? int'($urandom) : rc();
            r.bmin[a] = wild ? int'($urandom) : rc();
            if ($urandom_range(0, 7) == 0) r.bmax[a] = r.bmin[a] - int'($urandom_range(1, ONE));
            else r.bmax[a] = r.bmin[a] + int'($urandom_range(0, 4 * ONE));
            case ($urandom_range(0, 5))
                0:       r.inv[a] = 0;
                1:       r.inv[a] = int'($urandom);
                default: r.inv[a] = int'($urandom_range(0, 8 * ONE)) - 4 * ONE;
            endcase
        end
        r.tmin = int'($urandom_range(0, 6 * ONE)) - 2 * ONE;
        r.tmax = int'($urandom_range(0, 21 * ONE)) - ONE;
        return r;
    endfunction

    function automatic req_t mk_uni(input logic [7:0] tag, input int o, input int inv,
                                    input int mn, input int mx, input int tmn, input int tmx);
        req_t r;
        r.tag = tag;
        for (int a = 0; a < 3; a++) begin
            r.orig[a] = o; r.inv[a] = inv; r.bmin[a] = mn; r.bmax[a] = mx;
        end
        r.tmin = tmn;
        r.tmax = tmx;
        return r;
    endfunction

    task automatic drive(input req_t r);
        cur         = r;
        tag_in      = r.tag;
        ray_orig    = {r.orig[2], r.orig[1], r.orig[0]};
        ray_inv_dir = {r.inv[2], r.inv[1], r.inv[0]};
        box_min     = {r.bmin[2], r.bmin[1], r.bmin[0]};
        box_max     = {r.bmax[2], r.bmax[1], r.bmax[0]};
        t_min       = r.tmin;
        t_max       = r.tmax;
    endtask

    // Monitor/scoreboard: samples on the falling edge, between driver updates.
    initial begin
        exp_t e;
        logic       prev_st = 1'b0, p_hit = 1'b0;
        logic [7:0] p_tag = '0;
        logic [31:0] p_tn = '0, p_tf = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                q.delete();
                pr = 0; ph = 0; outs = 0; prev_st = 1'b0;
            end else begin
                check("perf_reqs", perf_reqs, pr);
                check("perf_hits", perf_hits, ph);
                check("perf4_reqs", {28'b0, perf_reqs4}, (pr > 15) ? 15 : pr);
                check("perf4_hits", {28'b0, perf_hits4}, (ph > 15) ? 15 : ph);
                if (valid_out && !ready_out) check("ready_in_stalled", {31'b0, ready_in}, 0);
                else check("ready_in_free", {31'b0, ready_in}, 1);
                if (prev_st) begin
                    check("hold_valid", {31'b0, valid_out}, 1);
                    check("hold_tag", {24'b0, tag_out}, {24'b0, p_tag});
                    check("hold_hit", {31'b0, hit_out}, {31'b0, p_hit});
                    check("hold_tn", t_near_out, p_tn);
                    check("hold_tf", t_far_out, p_tf);
                end
                if (valid_out && ready_out) begin
                    if (q.size() == 0) begin
                        check("spurious_out", {31'b0, valid_out}, 0);
                    end else begin
                        e = q.pop_front();
                        check("tag", {24'b0, tag_out}, {24'b0, e.tag});
                        check("hit", {31'b0, hit_out}, {31'b0, e.hit});
                        if (e.cmp_t) begin
                            check("t_near", t_near_out, e.tn);
                            check("t_far", t_far_out, e.tf);
                        end
                        if (e.stalls == stalls) check("latency", cyc - e.cyc, 4);
                        outs++;
                        if (e.hit) ph++;
                    end
                end
                if (valid_out && !ready_out) stalls++;
                if (valid_in && ready_in) begin
                    e = model(cur);
                    e.cyc = cyc;
                    e.stalls = stalls;
                    q.push_back(e);
                    pr++;
                end
                prev_st = valid_out && !ready_out;
                p_tag = tag_out; p_hit = hit_out; p_tn = t_near_out; p_tf = t_far_out;
            end
        end
    end

    task automatic send(input req_t r);
        int   n = 0;
        logic a = 1'b0;
        drive(r);
        valid_in = 1'b1;
        do begin
            @(negedge clk);
            a = ready_in;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 100);
        if (!a) check("send_timeout", {31'b0, a}, 1);
        valid_in = 1'b0;
    endtask

    task automatic run_one(input string name, input req_t r, input logic hit,
                           input int tn, input int tf, input bit cmp_t);
        int n = 0;
        send(r);
        do begin
            @(negedge clk);
            n++;
        end while (!valid_out && n < 20);
        check({name, "_lat"}, n, 4);
        check({name, "_hit"}, {31'b0, hit_out}, {31'b0, hit});
        check({name, "_tag"}, {24'b0, tag_out}, {24'b0, r.tag});
        if (cmp_t) begin
            check({name, "_tn"}, t_near_out, tn);
            check({name, "_tf"}, t_far_out, tf);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        req_t r;
        logic a;
        int   sent, i;
        bit   need_new;

        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
        drive(mk_uni(8'h00, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", {31'b0, valid_out}, 0);
        check("rst_hit", {31'b0, hit_out}, 0);
        check("rst_tag", {24'b0, tag_out}, 0);
        check("rst_tn", t_near_out, 0);
        check("rst_tf", t_far_out, 0);
        check("rst_perf_reqs", perf_reqs, 0);
        check("rst_perf_hits", perf_hits, 0);
        check("rst_ready_in", {31'b0, ready_in}, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_one("basic", mk_uni(8'h5a, 0, ONE, ONE, 2 * ONE, 0, 10 * ONE), 1'b1, ONE, 2 * ONE, 1);
        run_one("far", mk_uni(8'h11, 0, ONE, 3 * ONE, 4 * ONE, 0, 2 * ONE), 1'b0,
                3 * ONE, 2 * ONE, 1);
        r = mk_uni(8'h22, 0, ONE, ONE, 2 * ONE, 0, 10 * ONE);
        r.inv[0] = 0; r.orig[0] = 5 * ONE;
        run_one("par_out", r, 1'b0, 0, 0, 0);
        r.tag = 8'h23; r.orig[0] = ONE + ONE / 2;
        run_one("par_in", r, 1'b1, ONE, 2 * ONE, 1);
        r = mk_uni(8'h33, 0, ONE, ONE, 2 * ONE, 0, 10 * ONE);
        r.bmin[1] = 3 * ONE; r.bmax[1] = 2 * ONE;
        run_one("badbox", r, 1'b0, 2 * ONE, 2 * ONE, 1);
        run_one("neg_dir", mk_uni(8'h44, 0, -ONE, -2 * ONE, -ONE, 0, 10 * ONE), 1'b1,
                ONE, 2 * ONE, 1);
        r = mk_uni(8'h55, 0, 0, -ONE, ONE, 0, 32'h7fffffff);
        r.inv[0] = 32'h7fffffff; r.bmin[0] = 32'h7fffffff; r.bmax[0] = 32'h7fffffff;
        run_one("sat_pos", r, 1'b1, 32'h7fffffff, 32'h7fffffff, 1);
        r.tag = 8'h56; r.inv[0] = 32'h80000000;
        run_one("sat_neg", r, 1'b0, 0, 32'h80000000, 1);

        for (int k = 0; k < 600; k++) begin
            drive(rand_req(k[7:0]));
            valid_in  = ($urandom_range(0, 3) != 0);
            ready_out = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();
        check("perf4_saturated", {28'b0, perf_reqs4}, 15);

        // Back-to-back burst with downstream stalled for four cycles.
        pulse_reset();
        sent = 0; i = 0; need_new = 1;
        while (i < 60 && !(sent == 8 && q.size() == 0 && i > 10)) begin
            ready_out = !(i >= 3 && i <= 6);
            if (sent < 8) begin
                if (need_new) drive(rand_req(8'h80 + 8'(sent)));
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            a = valid_in && ready_in;
            if (i == 5) begin
                check("burst_stall_ready", {31'b0, ready_in}, 0);
                check("burst_stall_valid", {31'b0, valid_out}, 1);
            end
            @(posedge clk);
            #1;
            need_new = a;
            if (a) sent++;
            i++;
        end
        drain();
        check("burst_reqs", perf_reqs, 8);
        check("burst_outs", outs, 8);
        check("burst_hits", perf_hits, ph);

        // Reset while requests are in flight: none of them may emerge.
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            drive(rand_req(8'hc0 + 8'(k)));
            valid_in = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid_out", {31'b0, valid_out}, 0);
        check("midrst_ready_in", {31'b0, ready_in}, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrst_perf_reqs", perf_reqs, 0);
        check("midrst_outs", outs, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
